// File: rtl/rv32ima_pkg.sv
// Shared types and constants for the rv32ima front end.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam word_t RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_if.sv
// Instruction-memory request/grant/rvalid bus.
interface imem_if;
  import rv32ima_pkg::*;

  logic  req;
  word_t addr;
  logic  gnt;
  logic  rvalid;
  word_t rdata;
  logic  err;

  modport fetch (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport tb (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, held for decode.
// Optional fault reporting is enabled with FETCH_FAULT_EN.
module fetch_unit
  import rv32ima_pkg::*;
#(
  parameter word_t NOP_INST        = RV_NOP,
  parameter word_t ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic  clk,
  input  logic  nrst,
  input  word_t next_pc,
  input  logic  next_pc_en,
  input  logic  flush,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_gnt,
  input  logic  imem_rvalid,
  input  word_t imem_rdata,
  input  logic  imem_err,
  output logic  inst_valid,
  output word_t inst,
  output word_t inst_pc,
`ifdef FETCH_FAULT_EN
  output logic  inst_fault,
`endif
  input  logic  decode_ready,
  output logic  inst_ready
);

  imem_if bus ();

  fetch_state_t state_q, state_n;
  word_t addr_q, addr_n;
  word_t inst_q, inst_n;
  word_t ipc_q, ipc_n;
  logic  drop_q, drop_n;
  logic  pend_q, pend_n;
  logic  fault_q, fault_n;
  logic  launch;
  word_t launch_addr;

  assign bus.req    = (state_q == REQ);
  assign bus.addr   = addr_q & ADDR_ALIGN_MASK;
  assign bus.gnt    = imem_gnt;
  assign bus.rvalid = imem_rvalid;
  assign bus.rdata  = imem_rdata;
  assign bus.err    = imem_err;

  assign imem_req   = bus.req;
  assign imem_addr  = bus.addr;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_valid ? inst_q : NOP_INST;
  assign inst_pc    = ipc_q;
  assign inst_ready = inst_valid & decode_ready & ~flush;

`ifdef FETCH_FAULT_EN
  assign inst_fault = fault_q & inst_valid;
`else
  logic unused_err;
  assign unused_err = bus.err ^ fault_q;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      inst_q  <= inst_n;
      ipc_q   <= ipc_n;
      drop_q  <= drop_n;
      pend_q  <= pend_n;
      fault_q <= fault_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    inst_n      = inst_q;
    ipc_n       = ipc_q;
    drop_n      = drop_q;
    pend_n      = pend_q;
    fault_n     = fault_q;
    launch      = 1'b0;
    launch_addr = next_pc;
    unique case (state_q)
      IDLE: begin
        if (next_pc_en) launch = 1'b1;
      end
      REQ: begin
        if (flush && bus.gnt) begin
          // granted read cannot be recalled; park the redirect
          state_n = WAIT;
          drop_n  = 1'b1;
          pend_n  = next_pc_en;
          if (next_pc_en) addr_n = next_pc;
        end else if (flush) begin
          if (next_pc_en) launch = 1'b1;
          else            state_n = IDLE;
        end else if (bus.gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.rvalid && (drop_q || flush)) begin
          drop_n = 1'b0;
          pend_n = 1'b0;
          if (flush && next_pc_en) begin
            launch = 1'b1;
          end else if (pend_q) begin
            launch      = 1'b1;
            launch_addr = addr_q;
          end else begin
            state_n = IDLE;
          end
        end else if (bus.rvalid) begin
          state_n = HOLD;
          ipc_n   = addr_q;
          inst_n  = bus.rdata;
`ifdef FETCH_FAULT_EN
          fault_n = bus.err;
          if (bus.err) inst_n = NOP_INST;
`endif
        end else if (flush) begin
          drop_n = 1'b1;
          if (next_pc_en) begin
            pend_n = 1'b1;
            addr_n = next_pc;
          end
        end
      end
      HOLD: begin
        if (flush || decode_ready) begin
          if (next_pc_en) launch = 1'b1;
          else            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      addr_n  = launch_addr;
      state_n = REQ;
`ifdef FETCH_FAULT_EN
      fault_n = 1'b0;
      if (launch_addr[1:0] != 2'b00) begin
        state_n = HOLD;
        inst_n  = NOP_INST;
        ipc_n   = launch_addr;
        fault_n = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit.
module tb_fetch_unit;
  import rv32ima_pkg::*;

  logic  clk = 1'b0;
  logic  nrst;
  word_t next_pc;
  logic  next_pc_en;
  logic  flush;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;
  logic  imem_err;
  logic  inst_valid;
  word_t inst;
  word_t inst_pc;
  logic  decode_ready;
  logic  inst_ready;
`ifdef FETCH_FAULT_EN
  logic  inst_fault;
`endif

  localparam word_t NOP = 32'h0000_0013;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .nrst         (nrst),
    .next_pc      (next_pc),
    .next_pc_en   (next_pc_en),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_err     (imem_err),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
`ifdef FETCH_FAULT_EN
    .inst_fault   (inst_fault),
`endif
    .decode_ready (decode_ready),
    .inst_ready   (inst_ready)
  );

  typedef struct {
    logic  en;
    word_t pc;
    logic  fl;
    logic  gnt;
    logic  rv;
    word_t rd;
    logic  dr;
    logic  x_req;
    word_t x_addr;
    logic  x_val;
    word_t x_inst;
    word_t x_ipc;
    logic  x_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic en, input word_t pc, input logic fl,
    input logic gnt, input logic rv, input word_t rd,
    input logic dr, input logic x_req, input word_t x_addr,
    input logic x_val, input word_t x_inst, input word_t x_ipc,
    input logic x_rdy
  );
    vec_t v;
    v.en = en; v.pc = pc; v.fl = fl; v.gnt = gnt;
    v.rv = rv; v.rd = rd; v.dr = dr;
    v.x_req = x_req; v.x_addr = x_addr; v.x_val = x_val;
    v.x_inst = x_inst; v.x_ipc = x_ipc; v.x_rdy = x_rdy;
    return v;
  endfunction

  task automatic drive(
    input logic en, input word_t pc, input logic fl,
    input logic gnt, input logic rv, input word_t rd,
    input logic dr, input logic err
  );
    next_pc_en   = en;
    next_pc      = pc;
    flush        = fl;
    imem_gnt     = gnt;
    imem_rvalid  = rv;
    imem_rdata   = rd;
    decode_ready = dr;
    imem_err     = err;
  endtask

  // addr/pc are only meaningful while req/valid, unless strict
  task automatic check(
    input string nm, input logic req, input word_t addr,
    input logic val, input word_t ins, input word_t ipc,
    input logic rdy, input logic strict
  );
    logic bad;
    bad = (imem_req !== req) || (inst_valid !== val) ||
          (inst !== ins) || (inst_ready !== rdy);
    if ((req || strict) && imem_addr !== addr) bad = 1'b1;
    if ((val || strict) && inst_pc !== ipc) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h val=%b inst=%h pc=%h rdy=%b want req=%b addr=%h val=%b inst=%h pc=%h rdy=%b",
               nm, imem_req, imem_addr, inst_valid, inst, inst_pc,
               inst_ready, req, addr, val, ins, ipc, rdy);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    drive(0, '0, 0, 0, 0, '0, 0, 0);

    // zero-wait fetch of 0x100
    tbl.push_back(mk(1,32'h100,0,0,0,0,1, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h100,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h0050_0093,1, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,1,32'h0050_0093,32'h100,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,NOP,0,0));
    // grant stall on 0x104, then decode backpressure
    tbl.push_back(mk(1,32'h104,0,0,0,0,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 1,32'h104,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h00A0_0113,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,32'h00A0_0113,32'h104,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,32'h00A0_0113,32'h104,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,32'h00A0_0113,32'h104,0));
    tbl.push_back(mk(1,32'h108,0,0,0,0,1, 0,0,1,32'h00A0_0113,32'h104,1));
    // flush in WAIT with a redirect to 0x200
    tbl.push_back(mk(0,0,0,1,0,0,0, 1,32'h108,0,NOP,0,0));
    tbl.push_back(mk(1,32'h200,1,0,0,0,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'hDEAD_BEEF,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 1,32'h200,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h0000_0513,0, 0,0,0,NOP,0,0));
    // flush in HOLD beats decode_ready
    tbl.push_back(mk(0,0,1,0,0,0,1, 0,0,1,32'h0000_0513,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,NOP,0,0));
    // flush in REQ without grant
    tbl.push_back(mk(1,32'h300,0,0,0,0,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 1,32'h300,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,NOP,0,0));
    // flush in REQ with grant: response must be dropped
    tbl.push_back(mk(1,32'h304,0,0,0,0,0, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0, 1,32'h304,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h1111_1111,1, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,NOP,0,0));
    // stray rvalid while idle
    tbl.push_back(mk(0,0,0,0,1,32'h2222_2222,1, 0,0,0,NOP,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,NOP,0,0));

    #12;
    check("reset", 0, '0, 0, NOP, '0, 0, 1);
    step();
    nrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step();
      drive(tbl[i].en, tbl[i].pc, tbl[i].fl, tbl[i].gnt,
            tbl[i].rv, tbl[i].rd, tbl[i].dr, 0);
      #4;
      check($sformatf("vec%0d", i), tbl[i].x_req, tbl[i].x_addr,
            tbl[i].x_val, tbl[i].x_inst, tbl[i].x_ipc,
            tbl[i].x_rdy, 0);
    end

    // async reset while waiting on 0x400
    step(); drive(1, 32'h400, 0, 0, 0, '0, 0, 0);
    #4 check("rst_idle", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 1, 0, '0, 0, 0);
    #4 check("rst_req", 1, 32'h400, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 0, '0, 0, 0);
    #2 nrst = 1'b0;
    #1 check("rst_async", 0, '0, 0, NOP, '0, 0, 1);
    step(); nrst = 1'b1;
    drive(0, '0, 0, 0, 1, 32'hBAD0_BAD0, 1, 0);
    #4 check("rst_stale", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 0, '0, 1, 0);
    #4 check("rst_after", 0, '0, 0, NOP, '0, 0, 0);

`ifdef FETCH_FAULT_EN
    // misaligned address faults without a bus request
    step(); drive(1, 32'h102, 0, 0, 0, '0, 0, 0);
    #4 check("mis_idle", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 0, '0, 1, 0);
    #4 check("mis_hold", 0, '0, 1, NOP, 32'h102, 1, 0);
    n_vec++;
    if (inst_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_fault: got %b want 1", inst_fault);
    end
    step(); drive(0, '0, 0, 0, 0, '0, 1, 0);
    #4 check("mis_done", 0, '0, 0, NOP, '0, 0, 0);
    // bus error turns the response into a faulted NOP
    step(); drive(1, 32'h500, 0, 0, 0, '0, 0, 0);
    #4 check("err_idle", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 1, 0, '0, 0, 0);
    #4 check("err_req", 1, 32'h500, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 1, 32'h1234_5678, 0, 1);
    #4 check("err_wait", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 0, '0, 1, 0);
    #4 check("err_hold", 0, '0, 1, NOP, 32'h500, 1, 0);
    n_vec++;
    if (inst_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL err_fault: got %b want 1", inst_fault);
    end
`else
    // low bits masked on the bus; error flag ignored
    step(); drive(1, 32'h10A, 0, 0, 0, '0, 0, 0);
    #4 check("mis_idle", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 1, 0, '0, 0, 0);
    #4 check("mis_req", 1, 32'h108, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 1, 32'h0010_0073, 0, 1);
    #4 check("mis_wait", 0, '0, 0, NOP, '0, 0, 0);
    step(); drive(0, '0, 0, 0, 0, '0, 1, 0);
    #4 check("mis_hold", 0, '0, 1, 32'h0010_0073, 32'h10A, 1, 0);
`endif

    step(); drive(0, '0, 0, 0, 0, '0, 0, 0);
    #4 check("final_idle", 0, '0, 0, NOP, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC stage.
- Consumes next_pc/next_pc_en and issues one word read on the instruction-memory request/grant/rvalid bus.
- Holds the returned word for decode behind a valid/ready handshake, then pulses inst_ready back to the PC stage.
- Flushes any in-flight or held fetch on a branch redirect.

Parameters:
- NOP_INST, 32'h0000_0013, word presented on inst while inst_valid=0, and on faulted fetches.
- ADDR_ALIGN_MASK, 32'hFFFF_FFFC, mask applied to the latched PC before driving imem_addr.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- next_pc  input  32  address to fetch, from PC stage
- next_pc_en  input  1  next_pc valid this cycle
- flush  input  1  branch redirect; driven from branch_addr_en
- imem_req  output  1  memory read request
- imem_addr  output  32  memory read address
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid this cycle
- imem_rdata  input  32  read data
- imem_err  input  1  bus error, qualified by imem_rvalid
- inst_valid  output  1  inst/inst_pc valid for decode
- inst  output  32  fetched instruction
- inst_pc  output  32  address of inst
- decode_ready  input  1  decode accepts inst this cycle
- inst_ready  output  1  one-cycle pulse to PC stage: current instruction handed off

Behaviour:
- Interface: one clock, clk. Reset nrst is asynchronous, active-low. All state registers reset asynchronously.
- Reset values:
  - state=IDLE, drop=0
  - imem_req=0, imem_addr=0
  - inst_valid=0, inst=NOP_INST, inst_pc=0, inst_ready=0
- States:
  - IDLE: on next_pc_en, latch addr_r=next_pc, go to REQ.
  - REQ: imem_req=1, imem_addr=addr_r&ADDR_ALIGN_MASK. Address is held stable until imem_gnt. On imem_gnt, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - drop=0: latch inst_r=imem_rdata, inst_pc=addr_r, go to HOLD.
    - drop=1: discard the data, clear drop, go to IDLE.
  - HOLD: inst_valid=1. On decode_ready, pulse inst_ready for exactly the cycle of the handshake.
    - With next_pc_en in the same cycle: latch the new address and go to REQ.
    - Otherwise: go to IDLE.
- Latency: next_pc_en to imem_req is 1 cycle. rvalid to inst_valid is 1 cycle. Minimum next_pc_en to inst_valid is 3 cycles with zero-wait memory.
- Outstanding requests: at most one at any time.
- Flush (highest priority):
  - REQ without gnt: drop the request and go to IDLE. imem_req falls next cycle.
  - REQ with gnt in the same cycle: the transaction is committed. Go to WAIT with drop=1.
  - WAIT: set drop=1. A response arriving in the same cycle as flush is discarded.
  - HOLD: deassert inst_valid next cycle, go to IDLE. No inst_ready pulse, even if decode_ready=1.
  - flush together with next_pc_en, from IDLE/REQ/HOLD: latch the new address, go to REQ.
  - flush together with next_pc_en, from WAIT: set drop=1 and latch the new address as pending. Issue REQ after the dropped response returns.
- Ignored inputs:
  - next_pc_en in REQ/WAIT is ignored unless flush is asserted.
  - imem_rvalid outside WAIT is ignored.
- When inst_valid=0, inst is driven as NOP_INST.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- When defined:
  - Adds output inst_fault (1 bit), valid alongside inst_valid.
  - A misaligned latched address (addr_r[1:0]!=0) skips REQ/WAIT and goes directly to HOLD with inst=NOP_INST and inst_fault=1.
  - imem_err with rvalid in WAIT gives HOLD with inst=NOP_INST and inst_fault=1.
  - inst_fault resets to 0.
- When undefined:
  - There is no inst_fault port.
  - imem_err is ignored and imem_rdata is passed through as-is.
  - Low address bits are masked by ADDR_ALIGN_MASK.

Decomposition:
- rv32ima_pkg holds: word_t, enum fetch_state_t {IDLE, REQ, WAIT, HOLD}, constant RV_NOP=32'h0000_0013 (the default for NOP_INST).
- imem_if.svh: interface carrying the req/gnt/rvalid bus, with modports fetch and tb. It follows the layout of the PC interface.
- No sub-module. A single always_ff/always_comb pair is sufficient.

Test Plan:
- Zero-wait fetch:
  - Stimulus: next_pc=32'h0000_0100 with next_pc_en at cycle 0; gnt at cycle 1; rvalid at cycle 2 with rdata=32'h0050_0093; decode_ready=1.
  - Required: imem_addr=0x100 at cycle 1; inst_valid at cycle 3 with inst=0x00500093, inst_pc=0x100; single inst_ready pulse at cycle 3.
- Grant stall:
  - Stimulus: gnt held low for 4 cycles.
  - Required: imem_req and imem_addr=0x104 stable every cycle until gnt; then normal completion.
- Decode backpressure:
  - Stimulus: decode_ready=0 for 3 cycles in HOLD.
  - Required: inst/inst_pc held, no inst_ready pulse; pulse in the first cycle decode_ready=1.
- Flush in WAIT:
  - Stimulus: flush plus next_pc=0x200 with next_pc_en while waiting on 0x108; rvalid later returns 0xDEADBEEF.
  - Required: 0xDEADBEEF is never presented; next request addr=0x200; inst_pc=0x200.
- Flush in HOLD:
  - Stimulus: flush with decode_ready=1 in the same cycle.
  - Required: no inst_ready pulse; inst_valid=0 next cycle.
- Async reset mid-WAIT:
  - Stimulus: nrst low for 1 cycle mid-WAIT.
  - Required: all outputs at reset values immediately; a stale rvalid after reset is ignored.
  - With FETCH_FAULT_EN: next_pc=0x102 gives inst_fault=1, inst=NOP, and no imem_req.
